// File: rtl/inv_sweep_checker.sv
// inv_sweep_checker: sweeps every WIDTH-bit pattern into an inverter DUT and checks
// that each response is the bitwise complement, accumulating error statistics.
module inv_sweep_checker #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] fail_bits,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_pattern
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dut_in_q, dut_in_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH:0]   err_count_q, err_count_d;
    logic [WIDTH-1:0] fail_bits_q, fail_bits_d;
    logic             ffv_q, ffv_d;
    logic [WIDTH-1:0] ffp_q, ffp_d;
    logic [WIDTH-1:0] mism;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dut_in_d    = dut_in_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_bits_d = fail_bits_q;
        ffv_d       = ffv_q;
        ffp_d       = ffp_q;
        mism        = dut_out ^ ~dut_in_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d     = RUN;
                cnt_d       = '0;
                dut_in_d    = '0;
                done_d      = 1'b0;
                pass_d      = 1'b0;
                err_count_d = '0;
                fail_bits_d = '0;
                ffv_d       = 1'b0;
                ffp_d       = '0;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (cnt_q < CW'(SETTLE - 1)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            // Compare edge: the response to dut_in_q has had SETTLE cycles to settle.
            if (mism != '0) begin
                err_count_d = err_count_q + (WIDTH+1)'(1);
                fail_bits_d = fail_bits_q | mism;
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffp_d = dut_in_q;
                end
            end
            if (dut_in_q != '1) begin
                dut_in_d = dut_in_q + WIDTH'(1);
                cnt_d    = '0;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
                pass_d  = (err_count_d == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dut_in_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            fail_bits_q <= '0;
            ffv_q       <= 1'b0;
            ffp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dut_in_q    <= dut_in_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_bits_q <= fail_bits_d;
            ffv_q       <= ffv_d;
            ffp_q       <= ffp_d;
        end
    end

    assign dut_in             = dut_in_q;
    assign busy               = (state_q == RUN);
    assign done               = done_q;
    assign pass               = pass_q;
    assign err_count          = err_count_q;
    assign fail_bits          = fail_bits_q;
    assign first_fail_valid   = ffv_q;
    assign first_fail_pattern = ffp_q;
endmodule
